// File: rtl/cdb_pkg.sv
// Shared constants and types for the Common Data Bus broadcaster.
// Source indices name the execution units that feed the bus.
package cdb_pkg;

  localparam int NUM_SRC = 4;
  localparam int TAG_W   = 6;
  localparam int DATA_W  = 32;

  localparam int SRC_ALU = 0;
  localparam int SRC_MUL = 1;
  localparam int SRC_DIV = 2;
  localparam int SRC_LSU = 3;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_bus_t;

endpackage

// File: rtl/cdb_arbiter.sv
// Request-to-grant arbiter for the CDB holding registers.
// Build option CDB_RR_ARB_EN: round-robin with a pointer register; the
// search starts one past the last winner. Without it the arbiter is fixed
// priority (lowest index wins) and has no state.
// grant_o is one-hot or zero; grant_idx_o is the encoded winner (0 when idle).
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               upd_i,
  input  logic [NUM_SRC-1:0] req_i,
  output logic [NUM_SRC-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o
);

`ifdef CDB_RR_ARB_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               cand;

  // Scan forward from pointer+1, wrapping, and take the first requester.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = IDX_W'(cand);
      end
    end
  end

  // The pointer moves to the winner only when a grant actually retires.
  always_comb begin
    ptr_d = ptr_q;
    if (upd_i && found) ptr_d = grant_idx_o;
  end

  // Pointer register; reset so that source 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= IDX_W'(NUM_SRC - 1);
    else     ptr_q <= ptr_d;
  end
`else
  logic found;
  wire  unused_arb = ^{clk, rst, upd_i};

  // Fixed priority: the lowest-numbered requester wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && req_i[i]) begin
        found       = 1'b1;
        grant_o[i]  = 1'b1;
        grant_idx_o = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/cdb_broadcaster.sv
// Transmit end of the Common Data Bus.
// Each execution unit hands results over a valid/ready handshake into a
// one-entry holding register; an arbiter picks one held result per cycle
// and it is broadcast on a registered (valid, tag, data, src) bus.
// Build option CDB_RR_ARB_EN selects round-robin arbitration (see cdb_arbiter).
//
// Handshake: a result transfers on a rising edge where src_valid[i] and
// src_ready[i] are both high; tag/data are sampled only then. src_ready[i]
// is combinational: low during flush, otherwise high when the slot is empty
// or is being granted this cycle (allowing one transfer per cycle per source).
// Flush drops every held result and suppresses the next broadcast.
module cdb_broadcaster
  import cdb_pkg::*;
#(
  parameter int NUM_SRC = cdb_pkg::NUM_SRC,
  parameter int TAG_W   = cdb_pkg::TAG_W,
  parameter int DATA_W  = cdb_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic [NUM_SRC-1:0]          src_ready,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data,
  output logic [$clog2(NUM_SRC)-1:0]  cdb_src
);

  localparam int IDX_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] hold_v_q, hold_v_d;
  logic [TAG_W-1:0]   hold_tag_q  [NUM_SRC];
  logic [DATA_W-1:0]  hold_data_q [NUM_SRC];
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] accept;
  logic [IDX_W-1:0]   grant_idx;

  // Arbitration looks at held entries only; incoming results are never bypassed.
  cdb_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .upd_i       (~flush),
    .req_i       (hold_v_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign src_ready = {NUM_SRC{~flush}} & (~hold_v_q | grant);
  assign accept    = src_valid & src_ready;

  // Slot occupancy: flush clears, acceptance sets (even over a grant), grant clears.
  always_comb begin
    hold_v_d = hold_v_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (flush)          hold_v_d[i] = 1'b0;
      else if (accept[i]) hold_v_d[i] = 1'b1;
      else if (grant[i])  hold_v_d[i] = 1'b0;
    end
  end

  // Occupancy register; reset discards anything held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_v_q <= '0;
    else     hold_v_q <= hold_v_d;
  end

  // Payload capture on acceptance; contents are meaningless while the slot is empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (accept[i]) begin
        hold_tag_q[i]  <= src_tag[i*TAG_W +: TAG_W];
        hold_data_q[i] <= src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Broadcast register: valid follows the grant (killed by flush); payload holds when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
    end else begin
      cdb_valid <= (|grant) & ~flush;
      if (|grant) begin
        cdb_tag  <= hold_tag_q[grant_idx];
        cdb_data <= hold_data_q[grant_idx];
        cdb_src  <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Bench for cdb_broadcaster: directed scenarios followed by random traffic.
// A reference model tracks one pending result per source and predicts both
// src_ready and every broadcast; a monitor compares the CDB against the
// expected queue one clock after each predicted grant.
module tb_cdb_broadcaster;
  import cdb_pkg::*;

  localparam int N  = 4;
  localparam int TW = 6;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int EW = SW + TW + DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    src_valid;
  logic [N*TW-1:0] src_tag;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]    src_ready;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [SW-1:0]   cdb_src;

  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  // Reference state: pending result per source and the last winner.
  logic          m_hv   [N];
  logic [TW-1:0] m_tag  [N];
  logic [DW-1:0] m_data [N];
  int            last_w;

  cdb_broadcaster dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .src_valid (src_valid),
    .src_tag   (src_tag),
    .src_data  (src_data),
    .src_ready (src_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_winner();
`ifdef CDB_RR_ARB_EN
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last_w + k) % N;
      if (m_hv[c]) return c;
    end
`else
    for (int i = 0; i < N; i++) if (m_hv[i]) return i;
`endif
    return -1;
  endfunction

  // Reference model: evaluated mid-cycle with stable inputs, predicts the coming edge.
  always @(negedge clk) begin : model
    int w;
    logic [N-1:0] exp_rdy;
    if (rst) begin
      for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
      last_w = N - 1;
    end else begin
      w = pick_winner();
      for (int i = 0; i < N; i++) exp_rdy[i] = !flush && (!m_hv[i] || w == i);
      check("src_ready", src_ready, exp_rdy);
      if (w >= 0 && !flush) begin
        exp_q.push_back({SW'(w), m_tag[w], m_data[w]});
        last_w = w;
      end
      for (int i = 0; i < N; i++) begin
        if (flush) m_hv[i] = 1'b0;
        else if (src_valid[i] && exp_rdy[i]) begin
          m_hv[i]   = 1'b1;
          m_tag[i]  = src_tag[i*TW +: TW];
          m_data[i] = src_data[i*DW +: DW];
        end else if (w == i) m_hv[i] = 1'b0;
      end
    end
  end

  // Monitor: each edge must show exactly the broadcast predicted one cycle earlier.
  always @(posedge clk) begin : monitor
    logic [EW-1:0] e;
    logic exp_v;
    #2;
    if (!rst) begin
      exp_v = exp_q.size() > 0;
      check("cdb_valid", cdb_valid, exp_v);
      if (exp_v) begin
        e = exp_q.pop_front();
        if (cdb_valid) check("cdb_bus", {cdb_src, cdb_tag, cdb_data}, e);
      end
    end
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
    src_valid[i]        = v;
    src_tag[i*TW +: TW] = t;
    src_data[i*DW +: DW] = d;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    exp_q.delete();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    src_valid = '0;
    src_tag   = '0;
    src_data  = '0;
    last_w    = N - 1;
    repeat (2) next_cycle();

    // Reset values
    check("rst_cdb_valid", cdb_valid, 0);
    check("rst_cdb_tag", cdb_tag, 0);
    check("rst_cdb_data", cdb_data, 0);
    check("rst_cdb_src", cdb_src, 0);
    check("rst_src_ready", src_ready, 4'b1111);
    rst = 1'b0;
    next_cycle();

    // Single ALU result: broadcast exactly one cycle after the holding cycle
    set_src(SRC_ALU, 1'b1, 6'd5, 32'hDEAD_BEEF);
    next_cycle();
    src_valid = '0;
    check("alu_hold_cycle_valid", cdb_valid, 0);
    next_cycle();
    check("alu_bcast_valid", cdb_valid, 1);
    check("alu_bcast_tag", cdb_tag, 6'd5);
    check("alu_bcast_data", cdb_data, 32'hDEAD_BEEF);
    check("alu_bcast_src", cdb_src, 0);
    next_cycle();
    check("alu_after_valid", cdb_valid, 0);

    // All four sources at once from a fresh reset: tags 1..4 in order
    pulse_reset();
    for (int i = 0; i < N; i++) set_src(i, 1'b1, TW'(i + 1), 32'h1000 + i);
    next_cycle();
    src_valid = '0;
    for (int k = 0; k < N; k++) begin
      next_cycle();
      check("all4_order_tag", cdb_tag, k + 1);
    end
    repeat (2) next_cycle();

    // MUL streaming back-to-back
    for (int k = 0; k < 3; k++) begin
      set_src(SRC_MUL, 1'b1, TW'(10 + k), $urandom);
      next_cycle();
    end
    src_valid = '0;
    repeat (3) next_cycle();

    // ALU streams while DIV is held
    set_src(SRC_DIV, 1'b1, 6'd40, 32'hD1D1_0000);
    for (int k = 0; k < 5; k++) begin
      set_src(SRC_ALU, 1'b1, TW'(20 + k), $urandom);
      next_cycle();
      src_valid[SRC_DIV] = 1'b0;
    end
    src_valid = '0;
    repeat (3) next_cycle();

    // Flush with three entries held
    for (int i = 0; i < 3; i++) set_src(i, 1'b1, TW'(30 + i), $urandom);
    next_cycle();
    src_valid = '0;
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    check("flush_kills_bcast", cdb_valid, 0);
    set_src(SRC_LSU, 1'b1, 6'd50, 32'h5A5A_5A5A);
    next_cycle();
    src_valid = '0;
    repeat (3) next_cycle();

    // Random traffic with occasional flush and reset
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        set_src(i, ($urandom_range(0, 99) < 45), TW'($urandom), $urandom);
      flush = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 499) == 0) pulse_reset();
      else next_cycle();
    end
    src_valid = '0;
    flush     = 1'b0;
    repeat (6) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
- Transmit end of the Common Data Bus (CDB). The reservation-queue entries consume `cdb_valid`, `cdb_tag` and `cdb_data` to wake up waiting operands.
- Collects completed results from the execution units (ALU, MUL, DIV, LSU) through a valid/ready handshake. Each source has a 1-entry holding register.
- Arbitrates among sources and broadcasts at most one (tag, data) result per cycle on a registered CDB.
- Sits between the functional-unit writeback stage and the reservation stations / register status table / ROB.

Parameters:
- NUM_SRC, 4, number of result producers; index 0 = ALU, 1 = MUL, 2 = DIV, 3 = LSU.
- TAG_W, 6, destination tag width (matches the reservation-station tag width).
- DATA_W, 32, result data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush (mispredict/exception); synchronous.
- src_valid  in  NUM_SRC  per-source result valid.
- src_tag  in  NUM_SRC*TAG_W  per-source destination tag; source i occupies bits [i*TAG_W +: TAG_W].
- src_data  in  NUM_SRC*DATA_W  per-source result data; same slicing as `src_tag`.
- src_ready  out  NUM_SRC  per-source accept (combinational).
- cdb_valid  out  1  broadcast valid (registered).
- cdb_tag  out  TAG_W  broadcast tag (registered).
- cdb_data  out  DATA_W  broadcast data (registered).
- cdb_src  out  $clog2(NUM_SRC)  index of the winning source (registered; debug/ROB use).

Behaviour:
- Reset (asynchronous, active-high):
  - all hold_v = 0;
  - `cdb_valid`, `cdb_tag`, `cdb_data` and `cdb_src` = 0;
  - round-robin pointer = NUM_SRC-1, so source 0 wins first.
  - Reset mid-operation discards all held results.
- Handshake:
  - A result is accepted on a rising edge where `src_valid[i] & src_ready[i]`.
  - `src_ready[i] = ~flush & (~hold_v[i] | grant[i])`.
  - This allows back-to-back acceptance from one source while its held entry is being granted.
  - `src_tag`/`src_data` are sampled only on acceptance.
- Holding register i is loaded with {tag, data} on acceptance; `hold_v[i]` is set.
- `hold_v[i]` is cleared when granted, unless it is refilled in the same cycle.
- Arbitration: combinational over `hold_v` only; incoming data is never bypassed. `grant` is one-hot or zero.
- Broadcast register update each cycle:
  - `cdb_valid <= |grant & ~flush`;
  - `cdb_tag`/`cdb_data`/`cdb_src` load from the winner; they hold their old value when there is no grant.
- Latency: handshake at edge N → hold_v visible in cycle N+1 → `cdb_valid` high in cycle N+2. Minimum 2 cycles.
- Throughput: 1 broadcast per cycle aggregate and 1 per source per cycle sustained.
- Flush:
  - clears all hold_v and forces `cdb_valid` = 0 at the next edge;
  - `src_ready` = 0 during flush, so no acceptance;
  - flush has priority over acceptance and grant.
- All sources holding simultaneously: one grant per cycle; the others stall with `src_ready` = 0 until granted.
- Round-robin pointer updates to the granted index only when a grant occurs.

Optional Feature:
- Macro CDB_RR_ARB_EN.
- Defined: round-robin arbitration. Search starts at pointer+1 modulo NUM_SRC; the pointer updates on grant. This is starvation-free; the worst-case wait is NUM_SRC-1 cycles.
- Undefined: fixed priority, lowest index wins (ALU > MUL > DIV > LSU). The pointer register is not instantiated.

Decomposition:
- Package cdb_pkg:
  - TAG_W and DATA_W constants;
  - typedef `cdb_bus_t` {logic valid; logic [TAG_W-1:0] tag; logic [DATA_W-1:0] data};
  - source index constants SRC_ALU=0, SRC_MUL=1, SRC_DIV=2, SRC_LSU=3.
- One sub-module, cdb_arbiter: combinational request → grant plus the pointer register, with CDB_RR_ARB_EN handled inside.
- Holding registers and the broadcast register live in the top module.

Test Plan:
- Reset → `cdb_valid`=0, `cdb_tag`=0, `cdb_data`=0, `src_ready`=4'b1111.
- Single ALU result tag=6'd5, data=32'hDEAD_BEEF at edge 10 → `cdb_valid`=1, tag=5, data=DEADBEEF, `cdb_src`=0 in cycle 12 only; `cdb_valid`=0 in cycle 13.
- All 4 sources valid in the same cycle, tags 1..4:
  - with CDB_RR_ARB_EN: broadcasts in 4 consecutive cycles in order tags 1,2,3,4;
  - `src_ready[3]` stays low until its grant cycle.
- MUL streaming one result per cycle (tags 10,11,12) with no competition → `src_ready[1]` stays 1; CDB shows 10,11,12 on consecutive cycles.
- With CDB_RR_ARB_EN undefined: ALU asserts valid every cycle and DIV is held → DIV never granted while ALU streams; DIV is granted the cycle after ALU deasserts.
- Flush asserted while 3 entries are held → next cycle all hold_v=0 and `cdb_valid`=0; `src_ready`=0 during the flush cycle; normal operation resumes the cycle after.
